// File: rtl/uart_tx_oversampled.sv
// UART transmitter running on the receiver's oversampled clock: every bit is
// held for ps clock cycles, with start, LSB-first data, optional parity and stop.
module uart_tx_oversampled #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_data,
  input  logic                  Data_valid,
  input  logic                  Par_en,
  input  logic                  Par_type,
  input  logic [5:0]            Prescale,
  output logic                  TX_out,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [5:0]            ps;
  logic [5:0]            cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] data;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  bit_end;

  assign bit_end = (cnt == ps - 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ps       <= 6'd4;
      cnt      <= '0;
      idx      <= '0;
      data     <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      TX_out   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      // One shared cycle counter paces every non-idle bit.
      if (state != IDLE) cnt <= bit_end ? 6'd0 : cnt + 6'd1;

      case (state)
        IDLE: begin
          TX_out <= 1'b1;
          Busy   <= 1'b0;
          cnt    <= '0;
          if (Data_valid) begin
            data     <= P_data;
            ps       <= (Prescale < 6'd4) ? 6'd4 : Prescale;
            par_en_q <= Par_en;
            // Parity is resolved at accept so later stages only replay bits.
            par_bit  <= Par_type ? ~^P_data : ^P_data;
            TX_out   <= 1'b0;
            Busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            idx    <= '0;
            TX_out <= data[0];
            state  <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx == LAST_IDX) begin
              if (par_en_q) begin
                TX_out <= par_bit;
                state  <= PARITY;
              end else begin
                TX_out <= 1'b1;
                state  <= STOP;
              end
            end else begin
              idx    <= idx + 1'b1;
              TX_out <= data[idx + 1'b1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            TX_out <= 1'b1;
            state  <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          TX_out <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_oversampled.sv
// Directed bench for uart_tx_oversampled: table of frames with hand-derived
// bit sequences, plus back-to-back, mid-frame reset and ignored-request cases.
module tb_uart_tx_oversampled;

  logic       clk;
  logic       rst;
  logic [7:0] P_data;
  logic       Data_valid;
  logic       Par_en;
  logic       Par_type;
  logic [5:0] Prescale;
  logic       TX_out;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  uart_tx_oversampled #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_data     (P_data),
    .Data_valid (Data_valid),
    .Par_en     (Par_en),
    .Par_type   (Par_type),
    .Prescale   (Prescale),
    .TX_out     (TX_out),
    .Busy       (Busy)
  );

  // exp[i] is the i-th bit on the line (start bit first).
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [5:0]  presc;
    int          ps;
    int          nbits;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[6];
  vec_t v55;
  vec_t vaa;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input vec_t v);
    @(negedge clk);
    P_data     = v.data;
    Par_en     = v.pe;
    Par_type   = v.pt;
    Prescale   = v.presc;
    Data_valid = 1'b1;
  endtask

  // Called right after the accept edge. Scrambles the inputs once the frame
  // is accepted (unless chaining a next frame) and pulses Data_valid mid-frame.
  task automatic check_frame(input string name, input vec_t v,
                             input logic next_valid, input logic [7:0] next_data);
    int k;
    int bad;
    for (int b = 0; b < v.nbits; b++) begin
      bad = 0;
      for (int c = 0; c < v.ps; c++) begin
        @(negedge clk);
        k = b * v.ps + c;
        if (TX_out !== v.exp[b] || Busy !== 1'b1) bad++;
        if (k == 0) begin
          Data_valid = next_valid;
          if (next_valid) begin
            P_data = next_data;
          end else begin
            P_data   = ~v.data;
            Prescale = 6'd33;
            Par_en   = ~v.pe;
            Par_type = ~v.pt;
          end
        end
        if (!next_valid && k == 3 * v.ps)     Data_valid = 1'b1;
        if (!next_valid && k == 3 * v.ps + 1) Data_valid = 1'b0;
      end
      chk($sformatf("%s bit%0d bad_cycles", name, b), bad, 0);
    end
    @(negedge clk);
    chk({name, " busy_after_frame"}, int'(Busy), 0);
    chk({name, " line_after_frame"}, int'(TX_out), 1);
  endtask

  initial begin
    int bad;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd8,  8,  11, 12'h54A};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 6'd8,  8,  11, 12'h74A};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 6'd16, 16, 10, 12'h278};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 6'd2,  4,  10, 12'h200};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 6'd5,  5,  11, 12'h7FE};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 6'd0,  4,  11, 12'h502};
    v55     = '{8'h55, 1'b0, 1'b0, 6'd8,  8,  10, 12'h2AA};
    vaa     = '{8'hAA, 1'b0, 1'b0, 6'd8,  8,  10, 12'h354};

    rst        = 1'b1;
    P_data     = 8'h00;
    Data_valid = 1'b0;
    Par_en     = 1'b0;
    Par_type   = 1'b0;
    Prescale   = 6'd8;
    repeat (3) @(negedge clk);
    chk("reset tx", int'(TX_out), 1);
    chk("reset busy", int'(Busy), 0);
    rst = 1'b0;

    // Idle without a request stays idle.
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (Busy !== 1'b0 || TX_out !== 1'b1) bad++;
    end
    chk("idle no request", bad, 0);

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i]);
      check_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 8'h00);
      bad = 0;
      repeat (6) begin
        @(negedge clk);
        if (Busy !== 1'b0 || TX_out !== 1'b1) bad++;
      end
      chk($sformatf("vec%0d no_extra_frame", i), bad, 0);
    end

    // Back-to-back: Data_valid held high across both frames.
    start_frame(v55);
    check_frame("b2b_55", v55, 1'b1, 8'hAA);
    check_frame("b2b_aa", vaa, 1'b0, 8'h00);

    // Reset during data bit 3 while Prescale changes to 32 mid-frame.
    start_frame(vecs[0]);
    bad = 0;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (TX_out !== vecs[0].exp[k / 8] || Busy !== 1'b1) bad++;
      if (k == 1) begin
        Prescale   = 6'd32;
        Data_valid = 1'b0;
      end
    end
    chk("midframe prescale keeps 8", bad, 0);
    rst = 1'b1;
    #1;
    chk("async rst tx", int'(TX_out), 1);
    chk("async rst busy", int'(Busy), 0);
    @(negedge clk);
    rst = 1'b0;
    start_frame(vecs[2]);
    check_frame("after_rst", vecs[2], 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
